// File: rtl/udp_status_tx_pkg.sv
// Shared constants and types for the UDP status transmit framer.
// Covers UDP sizes, the default source port, the FSM encoding and the queued request layout.
package udp_status_tx_pkg;

  localparam int UDP_HDR_LEN        = 8;
  localparam int STATUS_PAYLOAD_LEN = 2;

  localparam logic [15:0] DEFAULT_LOCAL_PORT = 16'd8887;
  localparam logic [15:0] STATUS_UDP_LENGTH  = 16'(UDP_HDR_LEN + STATUS_PAYLOAD_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY0,
    ST_PAY1
  } state_t;

  typedef struct packed {
    logic [3:0] command;
    logic [3:0] data;
  } status_req_t;

endpackage

// File: rtl/status_req_fifo.sv
// Synchronous byte FIFO for queued status requests.
// Exposes a registered occupancy count together with full and empty flags.
module status_req_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: storage is left unreset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/udp_status_tx.sv
// UDP status framer: queues nibble status requests and sends each as a 2-byte datagram
// (request byte, then sequence number) to the most recently learned peer.
module udp_status_tx
  import udp_status_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] LOCAL_PORT = DEFAULT_LOCAL_PORT,
  parameter logic [7:0]  IP_TTL     = 8'd64,
  parameter logic [5:0]  IP_DSCP    = 6'd0,
  parameter logic [1:0]  IP_ECN     = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] local_ip,
  input  logic        tx_ready,
  input  logic [3:0]  tx_command,
  input  logic [3:0]  tx_data,
  input  logic        peer_update,
  input  logic [31:0] peer_ip,
  input  logic [15:0] peer_port,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic        busy,
  output logic [7:0]  drop_count
);

  // Request input stage, decoupling the controller strobe from the queue decision.
  logic        req_valid_q;
  status_req_t req_q;

  logic [31:0] peer_ip_q;
  logic [15:0] peer_port_q;
  logic        peer_known_q;

  logic [7:0]  drop_count_q;
  logic [7:0]  drop_count_d;

  logic                        fifo_push;
  logic                        fifo_pop;
  logic [7:0]                  fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        req_drop;

  state_t      state_q;
  logic        hdr_valid_q;
  logic        tvalid_q;
  logic        tlast_q;
  logic [7:0]  tdata_q;
  logic [7:0]  entry_q;
  logic [7:0]  seq_q;
  logic [31:0] dest_ip_q;
  logic [15:0] dest_port_q;
  logic [31:0] src_ip_q;

  assign fifo_push = req_valid_q && peer_known_q && !fifo_full;
  assign req_drop  = req_valid_q && !(peer_known_q && !fifo_full);
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  status_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (req_q),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: combinational next-state uses blocking '=' with a default first so no latch is inferred.
  always_comb begin
    drop_count_d = drop_count_q;
    if (req_drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  // NOTE: all state updates use '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q  <= 1'b0;
      req_q        <= '0;
      peer_ip_q    <= '0;
      peer_port_q  <= '0;
      peer_known_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      req_valid_q  <= tx_ready;
      req_q        <= '{command: tx_command, data: tx_data};
      drop_count_q <= drop_count_d;
      if (peer_update) begin
        peer_ip_q    <= peer_ip;
        peer_port_q  <= peer_port;
        peer_known_q <= 1'b1;
      end
    end
  end

  // Destination is captured when leaving IDLE so later peer updates only affect later frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_valid_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      entry_q     <= '0;
      seq_q       <= '0;
      dest_ip_q   <= '0;
      dest_port_q <= '0;
      src_ip_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            entry_q     <= fifo_dout;
            dest_ip_q   <= peer_ip_q;
            dest_port_q <= peer_port_q;
            src_ip_q    <= local_ip;
            hdr_valid_q <= 1'b1;
            state_q     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (m_udp_hdr_ready) begin
            hdr_valid_q <= 1'b0;
            tvalid_q    <= 1'b1;
            tdata_q     <= entry_q;
            tlast_q     <= 1'b0;
            state_q     <= ST_PAY0;
          end
        end
        ST_PAY0: begin
          if (m_udp_payload_axis_tready) begin
            tdata_q <= seq_q;
            tlast_q <= 1'b1;
            state_q <= ST_PAY1;
          end
        end
        ST_PAY1: begin
          if (m_udp_payload_axis_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            seq_q    <= seq_q + 8'd1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_udp_hdr_valid           = hdr_valid_q;
  assign m_udp_ip_dscp             = IP_DSCP;
  assign m_udp_ip_ecn              = IP_ECN;
  assign m_udp_ip_ttl              = IP_TTL;
  assign m_udp_ip_source_ip        = src_ip_q;
  assign m_udp_ip_dest_ip          = dest_ip_q;
  assign m_udp_source_port         = LOCAL_PORT;
  assign m_udp_dest_port           = dest_port_q;
  assign m_udp_length              = STATUS_UDP_LENGTH;
  assign m_udp_checksum            = 16'd0;
  assign m_udp_payload_axis_tdata  = tdata_q;
  assign m_udp_payload_axis_tvalid = tvalid_q;
  assign m_udp_payload_axis_tlast  = tlast_q;
  assign m_udp_payload_axis_tuser  = 1'b0;
  assign busy                      = (state_q != ST_IDLE) || (fifo_count != '0);
  assign drop_count                = drop_count_q;

endmodule
